stream_autocorrelator: RTL and testbench

STREAM_AUTOCORRELATOR -- requirements
Module: stream_autocorrelator

---
 rtl/autocorr_pkg.sv | 24 ++
 rtl/autocorr_mac.sv | 39 +++
 rtl/stream_autocorrelator.sv | 151 +++++++++++++++
 tb/tb_stream_autocorrelator.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/autocorr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : autocorr_pkg
// Description : Shared FSM state type and width helpers for the autocorrelator.
// Revision    : 1.0 - initial release
// ============================================================================
package autocorr_pkg;

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // Wide enough for FRAME_LEN products of the most negative sample squared.
    function automatic int acc_width(input int data_w, input int frame_len);
        return 2 * data_w + $clog2(frame_len);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/autocorr_mac.sv
`default_nettype none
// ============================================================================
// Module      : autocorr_mac
// Description : Signed multiply-accumulate for a single correlation lag.
// Revision    : 1.0 - initial release
// ============================================================================
module autocorr_mac
    import autocorr_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ACC_W  = acc_width(4, 8)
) (
    input  logic                     clk,
    input  logic                     i_clr,
    input  logic                     i_en,
    input  logic signed [DATA_W-1:0] i_a,
    input  logic signed [DATA_W-1:0] i_b,
    output logic signed [ACC_W-1:0]  o_acc
);

    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    r_acc;

    assign w_prod     = i_a * i_b;
    assign w_prod_ext = ACC_W'(w_prod);

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

    assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/stream_autocorrelator.sv
`default_nettype none
// ============================================================================
// Module      : stream_autocorrelator
// Description : Per-frame autocorrelation over lags 0..MAX_LAG-1, drained
//               one lag per handshake on a valid/ready output stream.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_autocorrelator
    import autocorr_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int MAX_LAG   = 4,
    parameter int FRAME_LEN = 8
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic signed [DATA_W-1:0]                   in_data,
    input  logic                                       in_valid,
    output logic                                       in_ready,
    output logic signed [acc_width(DATA_W, FRAME_LEN)-1:0] out_data,
    output logic [idx_width(MAX_LAG)-1:0]              out_lag,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic                                       out_last
);

    localparam int ACC_W = acc_width(DATA_W, FRAME_LEN);
    localparam int LAG_W = idx_width(MAX_LAG);
    localparam int CNT_W = idx_width(FRAME_LEN);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [CNT_W-1:0]         r_cnt;
    logic [LAG_W-1:0]         r_lag;
    logic                     w_accept;
    logic                     w_frame_end;
    logic                     w_is_last_lag;
    logic                     w_drain_done;
    logic                     w_clear;
    logic signed [DATA_W-1:0] w_tap [MAX_LAG];
    logic signed [ACC_W-1:0]  w_acc [MAX_LAG];
    logic signed [ACC_W-1:0]  w_sel;

    // Handshakes decode the registered state directly to keep the
    // output process free of combinational feedback.
    assign w_accept      = in_valid && (r_state == ST_ACCUM);
    assign w_frame_end   = w_accept && (r_cnt == CNT_W'(FRAME_LEN - 1));
    assign w_is_last_lag = (r_lag == LAG_W'(MAX_LAG - 1));
    assign w_drain_done  = (r_state == ST_DRAIN) && out_ready && w_is_last_lag;
    assign w_clear       = rst || w_drain_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        out_data    = '0;
        case (r_state)
            ST_ACCUM: begin
                in_ready = 1'b1;
                if (w_frame_end) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                out_data  = w_sel;
                out_last  = w_is_last_lag;
                if (out_ready && w_is_last_lag) begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            default: w_state_nxt = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_cnt <= '0;
            r_lag <= '0;
        end else begin
            if (w_frame_end) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if ((r_state == ST_DRAIN) && out_ready) begin
                r_lag <= r_lag + 1'b1;
            end
        end
    end

    assign out_lag = r_lag;

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < MAX_LAG; i++) begin
            if (r_lag == LAG_W'(i)) begin
                w_sel = w_acc[i];
            end
        end
    end

    // Tap k is x[n-k]; the delay line is zeroed per frame so early taps read 0.
    assign w_tap[0] = in_data;

    if (MAX_LAG > 1) begin : g_hist
        logic signed [DATA_W-1:0] r_hist [MAX_LAG-1];

        always_ff @(posedge clk) begin
            if (w_clear) begin
                for (int i = 0; i < MAX_LAG - 1; i++) begin
                    r_hist[i] <= '0;
                end
            end else if (w_accept) begin
                r_hist[0] <= in_data;
                for (int i = 1; i < MAX_LAG - 1; i++) begin
                    r_hist[i] <= r_hist[i-1];
                end
            end
        end

        for (genvar k = 1; k < MAX_LAG; k++) begin : g_tap
            assign w_tap[k] = r_hist[k-1];
        end
    end

    for (genvar k = 0; k < MAX_LAG; k++) begin : g_lag
        autocorr_mac #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
        ) u_mac (
            .clk   (clk),
            .i_clr (w_clear),
            .i_en  (w_accept),
            .i_a   (in_data),
            .i_b   (w_tap[k]),
            .o_acc (w_acc[k])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_stream_autocorrelator.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_autocorrelator
// Description : Directed self-checking bench for stream_autocorrelator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_autocorrelator;
    import autocorr_pkg::*;

    localparam int DATA_W    = 4;
    localparam int MAX_LAG   = 4;
    localparam int FRAME_LEN = 8;
    localparam int ACC_W     = acc_width(DATA_W, FRAME_LEN);
    localparam int LAG_W     = idx_width(MAX_LAG);

    logic                     clk = 1'b0;
    logic                     rst;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [ACC_W-1:0]  out_data;
    logic [LAG_W-1:0]         out_lag;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_last;

    int checks = 0;
    int errors = 0;

    stream_autocorrelator #(
        .DATA_W    (DATA_W),
        .MAX_LAG   (MAX_LAG),
        .FRAME_LEN (FRAME_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_lag   (out_lag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_frame(input logic signed [DATA_W-1:0] v [FRAME_LEN]);
        for (int n = 0; n < FRAME_LEN; n++) begin
            in_valid = 1'b1;
            in_data  = v[n];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic send_const(input int val);
        logic signed [DATA_W-1:0] v [FRAME_LEN];
        for (int n = 0; n < FRAME_LEN; n++) v[n] = DATA_W'(val);
        send_frame(v);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset(input string name);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 ||
            out_lag !== '0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL %s: in_ready=%0b out_valid=%0b out_data=%0d out_lag=%0d out_last=%0b, required 1 0 0 0 0",
                     name, in_ready, out_valid, out_data, out_lag, out_last);
        end
    endtask

    task automatic test_ones();
        int e [MAX_LAG] = '{8, 7, 6, 5};
        out_ready = 1'b1;
        send_const(1);
        for (int k = 0; k < MAX_LAG; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_lag !== LAG_W'(k) || out_data !== ACC_W'(e[k]) ||
                out_last !== (k == MAX_LAG - 1) || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL ones lag%0d: valid=%0b lag=%0d data=%0d last=%0b in_ready=%0b, required data=%0d",
                         k, out_valid, out_lag, out_data, out_last, in_ready, e[k]);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_lag !== '0) begin
            errors++;
            $display("FAIL ones_return: in_ready=%0b out_valid=%0b out_lag=%0d, required 1 0 0",
                     in_ready, out_valid, out_lag);
        end
    endtask

    task automatic test_alternating();
        int e [MAX_LAG] = '{8, -7, 6, -5};
        logic signed [DATA_W-1:0] v [FRAME_LEN];
        for (int n = 0; n < FRAME_LEN; n++) v[n] = (n % 2 == 0) ? 4'sd1 : -4'sd1;
        out_ready = 1'b1;
        send_frame(v);
        for (int k = 0; k < MAX_LAG; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_lag !== LAG_W'(k) || out_data !== ACC_W'(e[k]) ||
                out_last !== (k == MAX_LAG - 1)) begin
                errors++;
                $display("FAIL alternating lag%0d: valid=%0b lag=%0d data=%0d last=%0b, required data=%0d",
                         k, out_valid, out_lag, out_data, out_last, e[k]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_most_negative();
        int e [MAX_LAG] = '{512, 448, 384, 320};
        out_ready = 1'b1;
        send_const(-8);
        for (int k = 0; k < MAX_LAG; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_lag !== LAG_W'(k) || out_data !== ACC_W'(e[k])) begin
                errors++;
                $display("FAIL most_negative lag%0d: valid=%0b lag=%0d data=%0d, required data=%0d",
                         k, out_valid, out_lag, out_data, e[k]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_no_history_leak();
        int e1 [MAX_LAG] = '{392, 343, 294, 245};
        int e2 [MAX_LAG] = '{25, 0, 0, 0};
        logic signed [DATA_W-1:0] v [FRAME_LEN];
        out_ready = 1'b1;
        send_const(7);
        for (int k = 0; k < MAX_LAG; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_lag !== LAG_W'(k) || out_data !== ACC_W'(e1[k])) begin
                errors++;
                $display("FAIL sevens lag%0d: valid=%0b lag=%0d data=%0d, required data=%0d",
                         k, out_valid, out_lag, out_data, e1[k]);
            end
            @(posedge clk); #1;
        end
        for (int n = 0; n < FRAME_LEN; n++) v[n] = (n == 3) ? 4'sd5 : 4'sd0;
        send_frame(v);
        for (int k = 0; k < MAX_LAG; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_lag !== LAG_W'(k) || out_data !== ACC_W'(e2[k])) begin
                errors++;
                $display("FAIL no_leak lag%0d: valid=%0b lag=%0d data=%0d, required data=%0d",
                         k, out_valid, out_lag, out_data, e2[k]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int e [MAX_LAG] = '{8, 7, 6, 5};
        out_ready = 1'b0;
        send_const(1);
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0];
            in_data  = 4'sd7;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_lag !== '0 ||
                out_data !== ACC_W'(8) || out_last !== 1'b0) begin
                errors++;
                $display("FAIL backpressure cycle%0d: in_ready=%0b valid=%0b lag=%0d data=%0d last=%0b, required 0 1 0 8 0",
                         c, in_ready, out_valid, out_lag, out_data, out_last);
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        for (int k = 0; k < MAX_LAG; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_lag !== LAG_W'(k) || out_data !== ACC_W'(e[k]) ||
                out_last !== (k == MAX_LAG - 1)) begin
                errors++;
                $display("FAIL backpressure_drain lag%0d: valid=%0b lag=%0d data=%0d last=%0b, required data=%0d",
                         k, out_valid, out_lag, out_data, out_last, e[k]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_frame();
        out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            in_valid = 1'b1;
            in_data  = 4'sd5;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        pulse_reset();
        test_reset("reset_mid_frame");
        test_ones();
    endtask

    task automatic test_reset_mid_drain();
        out_ready = 1'b1;
        send_const(3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1 || out_lag !== LAG_W'(2) || out_data !== ACC_W'(54)) begin
            errors++;
            $display("FAIL mid_drain_pre: valid=%0b lag=%0d data=%0d, required 1 2 54",
                     out_valid, out_lag, out_data);
        end
        pulse_reset();
        test_reset("reset_mid_drain");
        test_ones();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        test_reset("reset");
        test_ones();
        test_alternating();
        test_most_negative();
        test_no_history_leak();
        test_backpressure();
        test_reset_mid_frame();
        test_reset_mid_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
